mux_scan: RTL

Parametrised registered N-channel, W-bit multiplexer with a built-in auto-scan sequencer. In manual mode it forwards the externally selected channel, like the fixed 4:1 selector. In scan mode it steps through all channels itself, holding each for a programmable number of cycles. It sits between parallel sample sources and a single downstream consumer, such as a display driver or a serial shifter, and replaces hand-wired select logic.

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_scan_scan_timer.sv | 62 ++++++
 rtl/mux_scan.sv | 90 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// mux_pkg -- shared mode encoding and select-width helper for mux_scan.
// Rev 1.0
`default_nettype none

package mux_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   function automatic int sel_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_scan_timer.sv
// scan_timer -- dwell counter and channel index for the mux_scan sequencer.
// Rev 1.0
`default_nettype none

module scan_timer
   import mux_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int DWELL = 4,
   localparam int SELW = sel_width(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_en,
   input  logic            i_hold,
   input  logic            i_load,
   input  logic [SELW-1:0] i_sel,
   output logic [SELW-1:0] o_ch,
   output logic            o_wrap_pre
);

   localparam int              DW           = $clog2(DWELL) + 1;
   localparam logic [DW-1:0]   c_DWELL_LAST = DW'(DWELL - 1);
   localparam logic [SELW-1:0] c_CH_LAST    = SELW'(N_CH - 1);

   logic [SELW-1:0] r_ch;
   logic [DW-1:0]   r_dwell;
   logic            r_wrap_pre;
   logic            w_advance;

   assign w_advance = i_en && !i_hold && (r_dwell == c_DWELL_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ch       <= '0;
         r_dwell    <= '0;
         r_wrap_pre <= 1'b0;
      end else begin
         // Marks the cycle after ch wrapped to 0; the output stage shows ch 0 next.
         r_wrap_pre <= w_advance && (r_ch == c_CH_LAST);
         if (!i_en) begin
            r_dwell <= '0;
            if (i_load) begin
               r_ch <= i_sel;
            end
         end else if (!i_hold) begin
            if (w_advance) begin
               r_dwell <= '0;
               r_ch    <= (r_ch == c_CH_LAST) ? '0 : r_ch + SELW'(1);
            end else begin
               r_dwell <= r_dwell + DW'(1);
            end
         end
      end
   end

   assign o_ch       = r_ch;
   assign o_wrap_pre = r_wrap_pre;

endmodule

`default_nettype wire

// File: rtl/mux_scan.sv
// mux_scan -- registered N-channel W-bit mux with manual select or auto-scan.
// Rev 1.0
`default_nettype none

module mux_scan
   import mux_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int W     = 8,
   parameter int DWELL = 4,
   localparam int SELW = sel_width(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH*W-1:0] in_data,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic              hold,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_ch,
   output logic              out_valid,
   output logic              wrap
);

   logic            w_scan;
   logic            w_legal_sel;
   logic            w_load;
   logic            w_cur_legal;
   logic            w_wrap_pre;
   logic [SELW-1:0] w_tim_ch;
   logic [SELW-1:0] w_cur_ch;
   logic [W-1:0]    w_data;

   logic [W-1:0]    r_data;
   logic [SELW-1:0] r_ch;
   logic            r_valid;
   logic            r_wrap;

   assign w_scan      = (mode_e'(mode) == MODE_SCAN);
   assign w_legal_sel = ({1'b0, sel} < (SELW + 1)'(N_CH));
   assign w_load      = !w_scan && w_legal_sel;
   assign w_cur_ch    = w_scan ? w_tim_ch : sel;
   assign w_cur_legal = w_scan || w_legal_sel;

   scan_timer #(
      .N_CH  (N_CH),
      .DWELL (DWELL)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (w_scan),
      .i_hold     (hold),
      .i_load     (w_load),
      .i_sel      (sel),
      .o_ch       (w_tim_ch),
      .o_wrap_pre (w_wrap_pre)
   );

   // Indices at or above N_CH match no channel and leave the data at zero.
   always_comb begin
      w_data = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (w_cur_ch == SELW'(c)) begin
            w_data = in_data[c*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_ch    <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_data  <= w_data;
         r_ch    <= w_cur_ch;
         r_valid <= w_cur_legal;
         r_wrap  <= w_scan && w_wrap_pre;
      end
   end

   assign out_data  = r_data;
   assign out_ch    = r_ch;
   assign out_valid = r_valid;
   assign wrap      = r_wrap;

endmodule

`default_nettype wire
